// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops bytes from an upstream FIFO with registered read data.
// Frame format is 8N1, LSB first, with one bit held for CLKS_PER_BIT clocks.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        fifo_empty,
  input  logic [7:0]  fifo_data,
  output logic        fifo_rd_en,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frames_sent
);

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StLatch,
    StStart,
    StData,
    StStop
  } state_e;

  localparam logic [15:0] BaudMax = 16'(CLKS_PER_BIT - 1);

  state_e      state_q;
  logic [7:0]  shift_q;
  logic [2:0]  bit_idx_q;
  logic [15:0] baud_q;
  logic        tx_q;
  logic        rd_en_q;
  logic [15:0] frames_q;
  logic        baud_done;

  assign baud_done = (baud_q == BaudMax);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= 8'h00;
      bit_idx_q <= 3'd0;
      baud_q    <= 16'd0;
      tx_q      <= 1'b1;
      rd_en_q   <= 1'b0;
      frames_q  <= 16'd0;
    end else begin
      rd_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          tx_q      <= 1'b1;
          baud_q    <= 16'd0;
          bit_idx_q <= 3'd0;
          if (enable && !fifo_empty) begin
            state_q <= StPop;
            rd_en_q <= 1'b1;
          end
        end
        StPop: begin
          state_q <= StLatch;
        end
        // FIFO read data is valid now, one cycle after the pop.
        StLatch: begin
          shift_q <= fifo_data;
          tx_q    <= 1'b0;
          baud_q  <= 16'd0;
          state_q <= StStart;
        end
        StStart: begin
          if (baud_done) begin
            baud_q  <= 16'd0;
            tx_q    <= shift_q[0];
            state_q <= StData;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        StData: begin
          if (baud_done) begin
            baud_q <= 16'd0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        StStop: begin
          if (baud_done) begin
            baud_q   <= 16'd0;
            frames_q <= frames_q + 16'd1;
            state_q  <= StIdle;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign fifo_rd_en  = rd_en_q;
  assign tx          = tx_q;
  assign busy        = (state_q != StIdle);
  assign frames_sent = frames_q;

endmodule
